// File: rtl/preg_free_list_pkg.sv
// Shared rename definitions: register counts, physical tag type, free-list
// pointer/count types, FSM states and wrap-bit pointer arithmetic.
package preg_free_list_pkg;

   localparam int NUM_PREGS = 64;
   localparam int NUM_AREGS = 32;
   localparam int TAG_W     = $clog2(NUM_PREGS);
   localparam int DEPTH     = NUM_PREGS - NUM_AREGS;
   localparam int IDX_W     = $clog2(DEPTH);
   localparam int PTR_W     = IDX_W + 1;
   localparam int CNT_W     = $clog2(DEPTH) + 1;

   typedef logic [TAG_W-1:0] ptag_t;
   typedef logic [PTR_W-1:0] fl_ptr_t;   // {wrap, index}
   typedef logic [CNT_W-1:0] fl_cnt_t;

   typedef enum logic {
      FL_NORMAL  = 1'b0,
      FL_RECOVER = 1'b1
   } fl_state_e;

   // Advance a wrap-bit pointer by 0..2; index wraps modulo DEPTH and the
   // wrap bit toggles on crossing.
   function automatic fl_ptr_t ptr_add(input fl_ptr_t p, input logic [1:0] n);
      logic [IDX_W:0] sum;
      fl_ptr_t        r;
      sum = (IDX_W+1)'(p[IDX_W-1:0]) + (IDX_W+1)'(n);
      if (sum >= (IDX_W+1)'(DEPTH))
         r = {~p[PTR_W-1], IDX_W'(sum - (IDX_W+1)'(DEPTH))};
      else
         r = {p[PTR_W-1], sum[IDX_W-1:0]};
      return r;
   endfunction

   // Entries from b up to a (a - b modulo 2*DEPTH).
   function automatic fl_cnt_t ptr_dist(input fl_ptr_t a, input fl_ptr_t b);
      logic [IDX_W:0] ai;
      logic [IDX_W:0] bi;
      ai = (IDX_W+1)'(a[IDX_W-1:0]);
      bi = (IDX_W+1)'(b[IDX_W-1:0]);
      if (a[PTR_W-1] != b[PTR_W-1])
         ai = ai + (IDX_W+1)'(DEPTH);
      return CNT_W'(ai - bi);
   endfunction

endpackage

// File: rtl/preg_free_list_if.sv
// Rename/retire <-> free-list handshake bundle. master = rename + ROB side,
// slave = the free list.
interface preg_free_list_if;
   import preg_free_list_pkg::*;

   logic    alloc_req_a;
   logic    alloc_req_b;
   logic    alloc_gnt;
   ptag_t   alloc_tag_a;
   ptag_t   alloc_tag_b;
   logic    ret_valid_a;
   ptag_t   ret_old_tag_a;
   logic    ret_valid_b;
   ptag_t   ret_old_tag_b;
   logic    flush;
   fl_cnt_t free_cnt;
   logic    busy;

   modport master (
      output alloc_req_a, alloc_req_b, ret_valid_a, ret_old_tag_a,
             ret_valid_b, ret_old_tag_b, flush,
      input  alloc_gnt, alloc_tag_a, alloc_tag_b, free_cnt, busy
   );

   modport slave (
      input  alloc_req_a, alloc_req_b, ret_valid_a, ret_old_tag_a,
             ret_valid_b, ret_old_tag_b, flush,
      output alloc_gnt, alloc_tag_a, alloc_tag_b, free_cnt, busy
   );

endinterface

// File: rtl/preg_fl_ptr.sv
// Wrap-bit free-list pointer: advance by 0/1/2 per cycle, or load a new
// value (load wins over advance).
module preg_fl_ptr
   import preg_free_list_pkg::*;
#(
   parameter fl_ptr_t RST_VAL = '0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] adv,
   input  logic       load,
   input  fl_ptr_t    load_val,
   output fl_ptr_t    ptr
);

   // Pointer register with async reset to its initial position.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     ptr <= RST_VAL;
      else if (load) ptr <= load_val;
      else           ptr <= ptr_add(ptr, adv);
   end

endmodule

// File: rtl/preg_free_list.sv
// Physical-register free list for a 2-wide rename stage. A speculative head
// serves rename, a committed head follows retire; flush copies the committed
// head back to the speculative head in one cycle.
module preg_free_list
   import preg_free_list_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   preg_free_list_if.slave  fl
);

   logic [DEPTH-1:0][TAG_W-1:0] entry;
   fl_state_e                   state;
   logic                        busy_q;
   fl_ptr_t                     spec_head, commit_head, tail;
   fl_ptr_t                     commit_nxt, spec_p1, tail_p1;
   logic [1:0]                  need, ret_n, spec_adv;
   fl_cnt_t                     free_cnt;
   logic                        gnt;
   logic [IDX_W-1:0]            wa_idx, wb_idx;

   // Request/retire counts, grant decision and write slots.
   always_comb begin
      need       = {1'b0, fl.alloc_req_a} + {1'b0, fl.alloc_req_b};
      ret_n      = {1'b0, fl.ret_valid_a} + {1'b0, fl.ret_valid_b};
      free_cnt   = ptr_dist(tail, spec_head);
      // All-or-nothing: both slots get tags or neither does.
      gnt        = (need != 2'd0) && (CNT_W'(need) <= free_cnt) &&
                   (state == FL_NORMAL) && !fl.flush && !reset;
      spec_adv   = gnt ? need : 2'd0;
      commit_nxt = ptr_add(commit_head, ret_n);
      spec_p1    = ptr_add(spec_head, 2'd1);
      tail_p1    = ptr_add(tail, 2'd1);
      wa_idx     = tail[IDX_W-1:0];
      wb_idx     = fl.ret_valid_a ? tail_p1[IDX_W-1:0] : tail[IDX_W-1:0];
   end

   assign fl.alloc_gnt   = gnt;
   assign fl.alloc_tag_a = entry[spec_head[IDX_W-1:0]];
   assign fl.alloc_tag_b = fl.alloc_req_a ? entry[spec_p1[IDX_W-1:0]]
                                          : entry[spec_head[IDX_W-1:0]];
   assign fl.free_cnt    = free_cnt;
   assign fl.busy        = busy_q;

   // Flush restores rename's view to the committed head, including any
   // retire happening in the same cycle.
   preg_fl_ptr #(.RST_VAL('0)) u_spec_head (
      .clk(clk), .reset(reset), .adv(spec_adv),
      .load(fl.flush), .load_val(commit_nxt), .ptr(spec_head)
   );

   preg_fl_ptr #(.RST_VAL('0)) u_commit_head (
      .clk(clk), .reset(reset), .adv(ret_n),
      .load(1'b0), .load_val('0), .ptr(commit_head)
   );

   // Tail starts one full lap ahead: every entry is free after reset.
   preg_fl_ptr #(.RST_VAL({1'b1, {IDX_W{1'b0}}})) u_tail (
      .clk(clk), .reset(reset), .adv(ret_n),
      .load(1'b0), .load_val('0), .ptr(tail)
   );

   // Tag storage: reset to the tags above the architectural set, then
   // refilled by retire; pushed tags are readable from the next cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            entry[i] <= TAG_W'(NUM_AREGS + i);
      end else begin
         if (fl.ret_valid_a) entry[wa_idx] <= fl.ret_old_tag_a;
         if (fl.ret_valid_b) entry[wb_idx] <= fl.ret_old_tag_b;
      end
   end

   // Recovery FSM: any flush (including one during recovery) leads to one
   // RECOVER cycle; busy is registered alongside the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= FL_NORMAL;
         busy_q <= 1'b0;
      end else begin
         case (state)
            FL_NORMAL:  state <= fl.flush ? FL_RECOVER : FL_NORMAL;
            FL_RECOVER: state <= fl.flush ? FL_RECOVER : FL_NORMAL;
            default:    state <= FL_NORMAL;
         endcase
         busy_q <= fl.flush;
      end
   end

   // Count never exceeds capacity.
   a_cnt_bound: assert property (@(posedge clk) disable iff (reset)
      free_cnt <= CNT_W'(DEPTH));

   // Retire frees at most what rename has handed out beyond the committed
   // head; this keeps commit_head behind spec_head and tail behind a lap.
   a_ret_bound: assert property (@(posedge clk) disable iff (reset)
      CNT_W'(ret_n) <= ptr_dist(spec_head, commit_head));

endmodule
